// File: rtl/envase_pkg.sv
// Definitions shared by the bottling-line blocks: station state encoding,
// count width and the press-time clamp.
package envase_pkg;

    localparam int LARGURA_CONTAGEM = 8;

    typedef enum logic [2:0] {
        OCIOSO        = 3'd0,
        VERIFICA      = 3'd1,
        AGUARDA_ROLHA = 3'd2,
        PRENSA        = 3'd3,
        LIBERA        = 3'd4,
        DESCARTE      = 3'd5,
        SAIDA         = 3'd6
    } estado_t;

    // A press time of zero is treated as one cycle.
    function automatic logic [LARGURA_CONTAGEM-1:0] tempo_efetivo(
        input logic [LARGURA_CONTAGEM-1:0] t);
        return (t == '0) ? LARGURA_CONTAGEM'(1) : t;
    endfunction

endpackage

// File: rtl/vedacao_rolha_if.sv
// Signal bundle between the corking station and its neighbours
// (conveyor/fill stage and cork-stock manager).
interface vedacao_rolha_if;

    logic                                   garrafa_presente;
    logic                                   cheia;
    logic [envase_pkg::LARGURA_CONTAGEM-1:0] CONTAGEM_ROLHAS_LINHA;
    logic                                   ACIONAR_DISPENSER;
    logic                                   done;
    logic                                   parar_esteira;
    logic                                   acionar_vedador;
    logic                                   descartar;
    logic                                   alerta_sem_rolha;
    logic [envase_pkg::LARGURA_CONTAGEM-1:0] contagem_vedadas;

    modport master (
        output garrafa_presente, cheia, CONTAGEM_ROLHAS_LINHA, ACIONAR_DISPENSER,
        input  done, parar_esteira, acionar_vedador, descartar, alerta_sem_rolha,
               contagem_vedadas
    );

    modport slave (
        input  garrafa_presente, cheia, CONTAGEM_ROLHAS_LINHA, ACIONAR_DISPENSER,
        output done, parar_esteira, acionar_vedador, descartar, alerta_sem_rolha,
               contagem_vedadas
    );

endinterface

// File: rtl/temporizador_vedacao.sv
// Loadable up-counter with terminal-count compare, usable for any timed
// actuator.
module temporizador_vedacao #(
    parameter int LARGURA = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               carregar,
    input  logic               incrementar,
    input  logic [LARGURA-1:0] valor_carga,
    input  logic [LARGURA-1:0] limite,
    output logic               terminal
);

    localparam logic [LARGURA-1:0] UM = LARGURA'(1);

    logic [LARGURA-1:0] contagem;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)            contagem <= '0;
        else if (carregar)    contagem <= valor_carga;
        else if (incrementar) contagem <= contagem + UM;
    end

    assign terminal = (contagem == limite);

endmodule

// File: rtl/vedacao_rolha.sv
// Corking station FSM: stops the bottle, waits for a cork, runs the press
// and reports each consumed cork to the stock manager with a done pulse.
module vedacao_rolha
    import envase_pkg::*;
#(
    parameter logic [LARGURA_CONTAGEM-1:0] TEMPO_VEDACAO = 8'd4
) (
    input logic            clk,
    input logic            reset,
    vedacao_rolha_if.slave bus
);

    localparam logic [LARGURA_CONTAGEM-1:0] LIMITE = tempo_efetivo(TEMPO_VEDACAO);
    localparam logic [LARGURA_CONTAGEM-1:0] UM     = LARGURA_CONTAGEM'(1);

    estado_t                     estado, proximo;
    logic                        fim_prensa;
    logic                        rolha_disponivel;
    logic                        entra_prensa;
    logic [LARGURA_CONTAGEM-1:0] contagem_q;

    assign rolha_disponivel = (bus.CONTAGEM_ROLHAS_LINHA != '0);
    assign entra_prensa     = (proximo == PRENSA) && (estado != PRENSA);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) estado <= OCIOSO;
        else       estado <= proximo;
    end

    always_comb begin
        // NOTE: defaulting to the current state keeps this process free of latches.
        proximo = estado;
        case (estado)
            OCIOSO:        if (bus.garrafa_presente) proximo = VERIFICA;
            VERIFICA: begin
                if (!bus.cheia)            proximo = DESCARTE;
                else if (rolha_disponivel) proximo = PRENSA;
                else                       proximo = AGUARDA_ROLHA;
            end
            AGUARDA_ROLHA: if (rolha_disponivel)       proximo = PRENSA;
            PRENSA:        if (fim_prensa)             proximo = LIBERA;
            LIBERA:        if (!bus.ACIONAR_DISPENSER) proximo = SAIDA;
            DESCARTE:                                  proximo = SAIDA;
            SAIDA:         if (!bus.garrafa_presente)  proximo = OCIOSO;
            default:                                   proximo = OCIOSO;
        endcase
    end

    always_comb begin
        bus.done             = 1'b0;
        bus.parar_esteira    = 1'b0;
        bus.acionar_vedador  = 1'b0;
        bus.descartar        = 1'b0;
        bus.alerta_sem_rolha = 1'b0;
        case (estado)
            VERIFICA:      bus.parar_esteira = 1'b1;
            AGUARDA_ROLHA: begin
                bus.parar_esteira    = 1'b1;
                bus.alerta_sem_rolha = 1'b1;
            end
            PRENSA: begin
                bus.parar_esteira   = 1'b1;
                bus.acionar_vedador = 1'b1;
            end
            // Holding done back during a refill keeps the consumed cork from
            // colliding with the manager's refill update.
            LIBERA: begin
                bus.parar_esteira = 1'b1;
                bus.done          = !bus.ACIONAR_DISPENSER;
            end
            DESCARTE: begin
                bus.parar_esteira = 1'b1;
                bus.descartar     = 1'b1;
            end
            default: ;
        endcase
    end

    temporizador_vedacao #(
        .LARGURA (LARGURA_CONTAGEM)
    ) u_temporizador (
        .clk         (clk),
        .reset       (reset),
        .carregar    (entra_prensa),
        .incrementar (estado == PRENSA),
        .valor_carga (UM),
        .limite      (LIMITE),
        .terminal    (fim_prensa)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                             contagem_q <= '0;
        else if (estado == LIBERA && !bus.ACIONAR_DISPENSER) contagem_q <= contagem_q + UM;
    end

    assign bus.contagem_vedadas = contagem_q;

endmodule
